// File: rtl/cp_est_ctrl_pkg.sv
// cp_est_ctrl_pkg: shared constants and data types for the CP-based ML
// timing/frequency estimator controller.
//   N/L/PIPE_DELAY  : symbol length, CP length, datapath latency
//   FIRST/START     : first full correlation window / first valid argmax
//   OFFSET          : phase of the argmax counter relative to the sample index
//   rho_t/theta_t/eps_t : SNR weight, timing result, CFO result
package cp_est_ctrl_pkg;
  localparam int N          = 256;
  localparam int L          = 16;
  localparam int PIPE_DELAY = 12;
  localparam int CNT_W      = 10;
  localparam int FRM_W      = 8;

  localparam int FIRST  = 2*N + L;
  localparam int START  = FIRST + PIPE_DELAY;
  localparam int OFFSET = START % N;
  localparam int T_W    = $clog2(START + 1);

  // Counter value held while idle so that sample s=0 sees (0-OFFSET) mod N.
  localparam logic [CNT_W-1:0] C_IDLE = CNT_W'(N - OFFSET);

  typedef logic [15:0]        rho_t;
  typedef logic [9:0]         theta_t;
  typedef logic signed [15:0] eps_t;

  typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_TRACK} state_e;
endpackage

// File: rtl/cp_est_ctrl_if.sv
// cp_est_ctrl_if: sample-stream, rho and result handshake bundle.
//   master : stream source / result sink (drives in_valid, rho_in, theta_in,
//            eps_in, out_ready)
//   slave  : the controller (drives cnt_o, rho_o, out_valid, theta_o, eps_o,
//            frame_idx, overrun, sync_lost)
interface cp_est_ctrl_if;
  import cp_est_ctrl_pkg::*;

  logic             in_valid;
  rho_t             rho_in;
  theta_t           theta_in;
  eps_t             eps_in;
  logic             out_ready;
  logic [CNT_W-1:0] cnt_o;
  rho_t             rho_o;
  logic             out_valid;
  theta_t           theta_o;
  eps_t             eps_o;
  logic [FRM_W-1:0] frame_idx;
  logic             overrun;
  logic             sync_lost;

  modport master (
    output in_valid, rho_in, theta_in, eps_in, out_ready,
    input  cnt_o, rho_o, out_valid, theta_o, eps_o, frame_idx, overrun, sync_lost
  );

  modport slave (
    input  in_valid, rho_in, theta_in, eps_in, out_ready,
    output cnt_o, rho_o, out_valid, theta_o, eps_o, frame_idx, overrun, sync_lost
  );
endinterface

// File: rtl/cp_res_hold.sv
// cp_res_hold: valid/ready result register for the estimator.
//   clk, rst            : clock, synchronous active-low reset
//   ev                  : a new argmax result is valid this cycle
//   theta_in, eps_in    : result to capture on ev
//   out_ready           : downstream accepts the held result
//   out_valid           : register holds an unaccepted result
//   theta_o, eps_o      : held result
//   frame_idx           : frame number of the held result
//   overrun             : sticky, an unaccepted result was overwritten
module cp_res_hold
  import cp_est_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             ev,
  input  theta_t           theta_in,
  input  eps_t             eps_in,
  input  logic             out_ready,
  output logic             out_valid,
  output theta_t           theta_o,
  output eps_t             eps_o,
  output logic [FRM_W-1:0] frame_idx,
  output logic             overrun
);
  logic             vld_q, vld_d;
  theta_t           theta_q, theta_d;
  eps_t             eps_q, eps_d;
  logic [FRM_W-1:0] fidx_q, fidx_d;
  logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
  logic             ovr_q, ovr_d;

  always_comb begin
    vld_d     = vld_q;
    theta_d   = theta_q;
    eps_d     = eps_q;
    fidx_d    = fidx_q;
    frm_cnt_d = frm_cnt_q;
    ovr_d     = ovr_q;
    if (ev) begin
      // Newest result always wins; losing an unaccepted one is flagged.
      vld_d     = 1'b1;
      theta_d   = theta_in;
      eps_d     = eps_in;
      fidx_d    = frm_cnt_q;
      frm_cnt_d = frm_cnt_q + 1'b1;
      if (vld_q && !out_ready) ovr_d = 1'b1;
    end else if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q     <= 1'b0;
      theta_q   <= '0;
      eps_q     <= '0;
      fidx_q    <= '0;
      frm_cnt_q <= '0;
      ovr_q     <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      theta_q   <= theta_d;
      eps_q     <= eps_d;
      fidx_q    <= fidx_d;
      frm_cnt_q <= frm_cnt_d;
      ovr_q     <= ovr_d;
    end
  end

  assign out_valid = vld_q;
  assign theta_o   = theta_q;
  assign eps_o     = eps_q;
  assign frame_idx = fidx_q;
  assign overrun   = ovr_q;
endmodule

// File: rtl/cp_est_ctrl.sv
// cp_est_ctrl: sequencer for the CP-based estimator datapath.
//   clk, rst : clock, synchronous active-low reset
//   bus      : cp_est_ctrl_if.slave -- sample stream in, argmax phase counter
//              and latched rho out, result valid/ready register out,
//              overrun / sync_lost status out.
// Tracks the sample index, drives the argmax phase counter, suppresses argmax
// wraps that occur before the pipeline has filled, and hands real results to
// cp_res_hold.
module cp_est_ctrl
  import cp_est_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  cp_est_ctrl_if.slave  bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] c_q, c_d, c_inc;
  logic [T_W-1:0]   t_q, t_d, t_inc;
  rho_t             rho_q, rho_d;
  logic             sync_lost_q, sync_lost_d;
  logic             ev;

  assign c_inc = (c_q == CNT_W'(N - 1)) ? '0 : c_q + 1'b1;
  // t saturates at START so a wrap is only a real result once warm-up is over.
  assign t_inc = (t_q == T_W'(START)) ? t_q : t_q + 1'b1;

  assign ev = bus.in_valid && (c_q == '0) && (t_q == T_W'(START)) &&
              (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    t_d         = t_q;
    rho_d       = rho_q;
    sync_lost_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_WARMUP;
          rho_d   = bus.rho_in;
          c_d     = c_inc;
          t_d     = t_inc;
        end
      end
      default: begin
        if (!bus.in_valid) begin
          state_d     = ST_IDLE;
          c_d         = C_IDLE;
          t_d         = '0;
          sync_lost_d = 1'b1;
        end else begin
          c_d = c_inc;
          t_d = t_inc;
          if (ev) state_d = ST_TRACK;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      c_q         <= C_IDLE;
      t_q         <= '0;
      rho_q       <= '0;
      sync_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      t_q         <= t_d;
      rho_q       <= rho_d;
      sync_lost_q <= sync_lost_d;
    end
  end

  logic             hold_vld;
  theta_t           hold_theta;
  eps_t             hold_eps;
  logic [FRM_W-1:0] hold_fidx;
  logic             hold_ovr;

  cp_res_hold u_hold (
    .clk       (clk),
    .rst       (rst),
    .ev        (ev),
    .theta_in  (bus.theta_in),
    .eps_in    (bus.eps_in),
    .out_ready (bus.out_ready),
    .out_valid (hold_vld),
    .theta_o   (hold_theta),
    .eps_o     (hold_eps),
    .frame_idx (hold_fidx),
    .overrun   (hold_ovr)
  );

  assign bus.cnt_o     = c_q;
  assign bus.rho_o     = rho_q;
  assign bus.sync_lost = sync_lost_q;
  assign bus.out_valid = hold_vld;
  assign bus.theta_o   = hold_theta;
  assign bus.eps_o     = hold_eps;
  assign bus.frame_idx = hold_fidx;
  assign bus.overrun   = hold_ovr;
endmodule

// File: tb/tb_cp_est_ctrl.sv
// tb_cp_est_ctrl: directed scenarios for cp_est_ctrl. Inputs change 1 time
// unit after a rising edge; outputs are sampled at the same point, so they
// reflect the edge just taken. Sample s carries theta=s+off, eps=3s+off.
module tb_cp_est_ctrl;
  import cp_est_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vec = 0;
  int   miscmp = 0;

  cp_est_ctrl_if bus();

  cp_est_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input int s, input int off);
    bus.in_valid = iv;
    bus.theta_in = theta_t'(s + off);
    bus.eps_in   = eps_t'(3*s + off);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.rho_in    = '0;
    bus.theta_in  = '0;
    bus.eps_in    = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [63:0] got, want;
    do_reset();
    got  = {6'd0, bus.cnt_o, bus.rho_o, bus.out_valid, bus.theta_o, bus.eps_o,
            bus.frame_idx, bus.overrun, bus.sync_lost};
    want = {6'd0, 10'd228, 16'h0, 1'b0, 10'h0, 16'h0, 8'h0, 1'b0, 1'b0};
    vec++;
    if (got !== want) begin
      miscmp++;
      $display("FAIL reset_state got %h want %h", got, want);
    end
  endtask

  task automatic test_continuous();
    logic exp_ev;
    int   k = 0;
    do_reset();
    bus.out_ready = 1'b1;
    bus.rho_in    = 16'h1234;
    for (int s = 0; s < 1100; s++) begin
      vec++;
      if (bus.cnt_o !== CNT_W'((s - OFFSET + 4*N) % N)) begin
        miscmp++;
        $display("FAIL cont_cnt s=%0d got %0d want %0d", s, bus.cnt_o, (s - OFFSET + 4*N) % N);
      end
      drive(1'b1, s, 0);
      exp_ev = (s == 540) || (s == 796) || (s == 1052);
      vec++;
      if (bus.out_valid !== exp_ev) begin
        miscmp++;
        $display("FAIL cont_valid s=%0d got %b want %b", s, bus.out_valid, exp_ev);
      end
      if (exp_ev) begin
        vec++;
        if ({bus.theta_o, bus.eps_o, bus.frame_idx} !== {theta_t'(s), eps_t'(3*s), FRM_W'(k)}) begin
          miscmp++;
          $display("FAIL cont_result s=%0d got theta=%0d eps=%0d frm=%0d want %0d %0d %0d",
                   s, bus.theta_o, bus.eps_o, bus.frame_idx, s, 3*s, k);
        end
        k++;
      end
    end
    vec++;
    if (bus.rho_o !== 16'h1234 || bus.overrun !== 1'b0) begin
      miscmp++;
      $display("FAIL cont_rho_ovr got rho=%h ovr=%b want 1234 0", bus.rho_o, bus.overrun);
    end
    drive(1'b0, 1100, 0);
    vec++;
    if (bus.sync_lost !== 1'b1 || bus.cnt_o !== 10'd228) begin
      miscmp++;
      $display("FAIL cont_break got sync_lost=%b cnt=%0d want 1 228", bus.sync_lost, bus.cnt_o);
    end
    tick();
    vec++;
    if (bus.sync_lost !== 1'b0) begin
      miscmp++;
      $display("FAIL cont_break_pulse got sync_lost=%b want 0", bus.sync_lost);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int s = 0; s <= 797; s++) begin
      drive(1'b1, s, 0);
      if (s == 540) begin
        vec++;
        if ({bus.out_valid, bus.theta_o, bus.frame_idx, bus.overrun} !== {1'b1, 10'd540, 8'd0, 1'b0}) begin
          miscmp++;
          $display("FAIL ovr_first got v=%b th=%0d frm=%0d ovr=%b want 1 540 0 0",
                   bus.out_valid, bus.theta_o, bus.frame_idx, bus.overrun);
        end
      end
      if (s == 796) begin
        vec++;
        if ({bus.out_valid, bus.theta_o, bus.eps_o, bus.frame_idx, bus.overrun} !==
            {1'b1, theta_t'(796), eps_t'(3*796), 8'd1, 1'b1}) begin
          miscmp++;
          $display("FAIL ovr_second got v=%b th=%0d eps=%0d frm=%0d ovr=%b want 1 796 2388 1 1",
                   bus.out_valid, bus.theta_o, bus.eps_o, bus.frame_idx, bus.overrun);
        end
      end
    end
    bus.out_ready = 1'b1;
    drive(1'b1, 798, 0);
    vec++;
    if (bus.out_valid !== 1'b0 || bus.overrun !== 1'b1) begin
      miscmp++;
      $display("FAIL ovr_accept got v=%b ovr=%b want 0 1", bus.out_valid, bus.overrun);
    end
    drive(1'b0, 0, 0);
  endtask

  task automatic test_accept_on_event();
    do_reset();
    for (int s = 0; s <= 797; s++) begin
      bus.out_ready = (s == 796);
      drive(1'b1, s, 0);
      if (s == 795) begin
        vec++;
        if (bus.out_valid !== 1'b1 || bus.theta_o !== 10'd540) begin
          miscmp++;
          $display("FAIL acc_pending got v=%b th=%0d want 1 540", bus.out_valid, bus.theta_o);
        end
      end
      if (s == 796 || s == 797) begin
        vec++;
        if ({bus.out_valid, bus.theta_o, bus.frame_idx, bus.overrun} !== {1'b1, theta_t'(796), 8'd1, 1'b0}) begin
          miscmp++;
          $display("FAIL acc_event s=%0d got v=%b th=%0d frm=%0d ovr=%b want 1 796 1 0",
                   s, bus.out_valid, bus.theta_o, bus.frame_idx, bus.overrun);
        end
      end
    end
    drive(1'b0, 0, 0);
  endtask

  task automatic test_break_rho();
    do_reset();
    bus.rho_in = 16'h1111;
    for (int s = 0; s < 600; s++) begin
      if (s == 300) bus.rho_in = 16'h5555;
      drive(1'b1, s, 0);
    end
    vec++;
    if (bus.rho_o !== 16'h1111 || bus.out_valid !== 1'b1 || bus.theta_o !== 10'd540) begin
      miscmp++;
      $display("FAIL brk_pre got rho=%h v=%b th=%0d want 1111 1 540", bus.rho_o, bus.out_valid, bus.theta_o);
    end
    drive(1'b0, 600, 0);
    vec++;
    if ({bus.sync_lost, bus.cnt_o, bus.out_valid, bus.theta_o, bus.frame_idx} !==
        {1'b1, 10'd228, 1'b1, 10'd540, 8'd0}) begin
      miscmp++;
      $display("FAIL brk_gap got sl=%b cnt=%0d v=%b th=%0d frm=%0d want 1 228 1 540 0",
               bus.sync_lost, bus.cnt_o, bus.out_valid, bus.theta_o, bus.frame_idx);
    end
    bus.rho_in = 16'hBEEF;
    for (int s = 0; s <= 540; s++) begin
      drive(1'b1, s, 100);
      if (s == 0) begin
        bus.rho_in = 16'h7777;
        vec++;
        if (bus.sync_lost !== 1'b0 || bus.rho_o !== 16'hBEEF) begin
          miscmp++;
          $display("FAIL brk_restart got sl=%b rho=%h want 0 beef", bus.sync_lost, bus.rho_o);
        end
      end
      if (s == 539) begin
        vec++;
        if (bus.out_valid !== 1'b1 || bus.theta_o !== 10'd540 || bus.overrun !== 1'b0) begin
          miscmp++;
          $display("FAIL brk_warmup got v=%b th=%0d ovr=%b want 1 540 0", bus.out_valid, bus.theta_o, bus.overrun);
        end
      end
      if (s == 540) begin
        vec++;
        if ({bus.out_valid, bus.theta_o, bus.frame_idx, bus.overrun, bus.rho_o} !==
            {1'b1, theta_t'(640), 8'd1, 1'b1, 16'hBEEF}) begin
          miscmp++;
          $display("FAIL brk_event got v=%b th=%0d frm=%0d ovr=%b rho=%h want 1 640 1 1 beef",
                   bus.out_valid, bus.theta_o, bus.frame_idx, bus.overrun, bus.rho_o);
        end
      end
    end
    drive(1'b0, 0, 0);
  endtask

  task automatic test_reset_mid();
    logic [63:0] got, want;
    do_reset();
    bus.rho_in = 16'h4242;
    for (int s = 0; s <= 800; s++) drive(1'b1, s, 0);
    vec++;
    if (bus.out_valid !== 1'b1 || bus.overrun !== 1'b1 || bus.rho_o !== 16'h4242) begin
      miscmp++;
      $display("FAIL rmid_pre got v=%b ovr=%b rho=%h want 1 1 4242", bus.out_valid, bus.overrun, bus.rho_o);
    end
    rst = 1'b0;
    drive(1'b1, 801, 0);
    got  = {6'd0, bus.cnt_o, bus.rho_o, bus.out_valid, bus.theta_o, bus.eps_o,
            bus.frame_idx, bus.overrun, bus.sync_lost};
    want = {6'd0, 10'd228, 16'h0, 1'b0, 10'h0, 16'h0, 8'h0, 1'b0, 1'b0};
    vec++;
    if (got !== want) begin
      miscmp++;
      $display("FAIL rmid_state got %h want %h", got, want);
    end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int s = 0; s <= 540; s++) drive(1'b1, s, 200);
    vec++;
    if ({bus.out_valid, bus.theta_o, bus.frame_idx, bus.overrun} !== {1'b1, theta_t'(740), 8'd0, 1'b0}) begin
      miscmp++;
      $display("FAIL rmid_first got v=%b th=%0d frm=%0d ovr=%b want 1 740 0 0",
               bus.out_valid, bus.theta_o, bus.frame_idx, bus.overrun);
    end
    drive(1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_overrun();
    test_accept_on_event();
    test_break_rho();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule

// File: doc/cp_est_ctrl.md
# cp_est_ctrl

Sequencer and result handshake controller for the CP-based ML timing/frequency estimator datapath (delay line, phi/gamma sums, mag/angle, minus, argmax). It tracks the input sample stream and drives the argmax phase counter. It suppresses results during pipeline warm-up and captures each symbol's theta/epsilon into a valid/ready output register. It also latches rho once per stream and detects stream breaks.

## Interface
- N, 256: symbol (FFT) length in samples
- L, 16: cyclic-prefix length in samples
- PIPE_DELAY, 12: datapath latency in cycles, from sample input to argmax result
- CNT_W, 10: width of argmax phase counter
- FRM_W, 8: width of frame index
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  sample present on datapath input this cycle
- rho_in  in  rho_t  requested SNR weight
- theta_in  in  theta_t  argmax timing result
- eps_in  in  eps_t  argmax CFO result
- out_ready  in  1  downstream accepts result
- cnt_o  out  CNT_W  phase counter to argmax count input
- rho_o  out  rho_t  latched rho to phi_sum/minus
- out_valid  out  1  result register holds unaccepted result
- theta_o  out  theta_t  held timing result
- eps_o  out  eps_t  held CFO result
- frame_idx  out  FRM_W  index of the result held in theta_o/eps_o
- overrun  out  1  sticky: a result was overwritten before acceptance
- sync_lost  out  1  one-cycle pulse on stream break

## Operation
- Constants: FIRST = 2N+L (528), START = FIRST+PIPE_DELAY (540), OFFSET = START mod N (28).
- Sample index s: counts in_valid cycles from stream start; s=0 is the cycle that leaves IDLE.
- Phase counter c: cnt_o = (s − OFFSET) mod N during the sample-s cycle. In IDLE, c holds N−OFFSET (228). c increments on each in_valid and wraps from N−1 to 0.
- Total counter t: equals s and saturates at START; width is $clog2(START+1).
- Event E (combinational): in_valid && c==0 && t==START && state≠IDLE. Cycles with c==0 and s<START (s=28, 284) are warm-up and are suppressed.
- FSM:
  - IDLE → WARMUP on in_valid. That same cycle latches rho_o <= rho_in, and t and c advance.
  - WARMUP → TRACK on the first E.
  - WARMUP or TRACK → IDLE on in_valid==0. This reloads c=228 and t=0, and sync_lost pulses on the next cycle.
  - TRACK stays in TRACK while in_valid stays high.
- rho_o changes only on the IDLE→WARMUP transition. rho_in is ignored at all other times.
- Result register behaviour on event E:
  - E loads theta_in and eps_in into theta_o and eps_o, and sets out_valid=1.
  - frame_idx loads a frame counter value, then the counter increments, wrapping at 2^FRM_W.
- Result register handshake:
  - out_valid && out_ready with no E: out_valid clears.
  - E with out_valid && !out_ready: the register is overwritten with the newest result and overrun is set.
  - E together with out_valid && out_ready: the register loads the new result, out_valid stays 1, and overrun is not set.
- A stream break does not touch the result register. A pending result stays held until accepted.
- The frame counter continues across stream breaks and is cleared only by reset.

## Timing
- Reset (rst=0 at an edge) sets the following values. Reset dominates all other events, including mid-stream and with a pending result.
  - state=IDLE, c=228, t=0, rho_o=0, out_valid=0
  - theta_o=0, eps_o=0, frame_idx=0, frame counter=0
  - overrun=0, sync_lost=0
- cnt_o, rho_o and all outputs are registered. No combinational path from inputs to outputs.
- E occurs during the cycle of sample s. out_valid, theta_o, eps_o and frame_idx update at the following edge, so latency is 1 cycle.
- For a continuous stream, E occurs at s = 540 + kN (540, 796, 1052, …).
- After a break, the next E occurs at s=540 of the new stream.
- out_valid can fall only on an accept cycle, and rises or stays high on E.

## Structure
- The following belong in the shared data_type package: N, L, PIPE_DELAY, the derived FIRST, START and OFFSET, and the rho_t, theta_t and eps_t types.
- One sub-module, cp_res_hold, holds the valid/ready result register, the overwrite and overrun logic, and the frame_idx load.
- The FSM and the c/t counters stay in cp_est_ctrl.

## Test plan
- Continuous 1100 samples, out_ready=1: out_valid pulses 1 cycle after s=540, 796, 1052, with frame_idx 0, 1, 2. theta_o/eps_o equal theta_in/eps_in at those cycles. No pulse after s=28 or s=284.
- out_ready=0 through s=540 and s=796: overrun=1. theta_o holds the s=796 value and frame_idx=1. Raising out_ready then clears out_valid next cycle, and overrun stays 1.
- out_ready=1 only in the s=796 cycle, with a result pending from s=540: out_valid stays 1, frame_idx=1, overrun=0.
- in_valid low one cycle at s=600 with a result pending: sync_lost pulses once and state returns to IDLE. cnt_o=228 during the gap, and the pending result is retained. The next E occurs 540 samples after restart.
- rho_in changed at s=300: rho_o unchanged. After a break and restart, rho_o equals rho_in from the restart cycle.
- rst=0 mid-TRACK with out_valid=1 and overrun=1: at the next edge all outputs take their reset values and cnt_o=228. The first E after restart reports frame_idx=0.
